// File: rtl/health_pkg.sv
// health_pkg: shared state encoding and default parameters for the health tracker
package health_pkg;
  typedef enum logic [1:0] {INIT, ALIVE, INVULN, DEAD} health_state_t;
  localparam int DEFAULT_MAX_HEALTH = 3;
  localparam int DEFAULT_INVULN_CYCLES = 60;
endpackage

// File: rtl/invuln_timer.sv
// invuln_timer: loadable down-counter that holds at zero; done_o flags an empty window
module invuln_timer import health_pkg::*; #(
  parameter int IW = 6,
  parameter logic [IW-1:0] LOAD_VAL = '0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic load_i,
  input  logic en_i,
  output logic done_o
);
  logic [IW-1:0] cnt_q, cnt_d;
  // next count: clear wins, then load, then decrement while enabled and non-zero
  always_comb begin
    cnt_d = clear_i ? '0 : load_i ? LOAD_VAL : (en_i && cnt_q != '0) ? cnt_q - IW'(1) : cnt_q;
  end
  // counter register with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign done_o = cnt_q == '0;
endmodule

// File: rtl/health_tracker.sv
// health_tracker: health/invulnerability FSM; heal support enabled by macro HEALTH_TRACKER_HEAL_EN
module health_tracker import health_pkg::*; #(
  parameter int MAX_HEALTH = DEFAULT_MAX_HEALTH,
  parameter int INVULN_CYCLES = DEFAULT_INVULN_CYCLES,
  localparam int HW = $clog2(MAX_HEALTH + 1),
  localparam int IW = $clog2(INVULN_CYCLES + 1)
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          restart,
  input  logic          collision,
  input  logic [HW-1:0] dmg,
  input  logic          heal,
  output logic [HW-1:0] healthCount,
  output logic          gameEnd,
  output logic          invulnerable,
  output logic          hitPulse
);
  localparam logic [HW-1:0] MAXV = HW'(MAX_HEALTH);
  localparam logic [HW-1:0] ONE = HW'(1);
  health_state_t state_q;
  logic [HW-1:0] health_q, dmg_eff, hit_health, hit_heal, cur_heal;
  logic coll_q, game_end_q, invuln_q, hit_q, rise, load, done;
  // damage arithmetic: zero damage counts as one, result saturates at zero
  always_comb begin
    rise = collision & ~coll_q;
    dmg_eff = (dmg == '0) ? ONE : dmg;
    hit_health = (dmg_eff >= health_q) ? '0 : health_q - dmg_eff;
    load = (state_q == ALIVE) && rise && (hit_health != '0) && !restart;
  end
`ifdef HEALTH_TRACKER_HEAL_EN
  assign hit_heal = (heal && hit_health != MAXV) ? hit_health + ONE : hit_health;
  assign cur_heal = (heal && health_q != MAXV) ? health_q + ONE : health_q;
`else
  logic unused_heal;
  assign unused_heal = heal;
  assign hit_heal = hit_health;
  assign cur_heal = health_q;
`endif
  invuln_timer #(.IW(IW), .LOAD_VAL(IW'(INVULN_CYCLES - 1))) u_timer (
    .clk_i(Clk),
    .rst_ni(Reset_n),
    .clear_i(restart),
    .load_i(load),
    .en_i(state_q == INVULN),
    .done_o(done)
  );
  // main FSM with registered outputs; restart overrides every state
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= INIT;
      health_q <= MAXV;
      game_end_q <= 1'b0;
      invuln_q <= 1'b0;
      hit_q <= 1'b0;
      coll_q <= 1'b1;
    end else begin
      coll_q <= collision;
      hit_q <= 1'b0;
      if (restart) begin
        state_q <= INIT;
        health_q <= MAXV;
        game_end_q <= 1'b0;
        invuln_q <= 1'b0;
      end else begin
        case (state_q)
          INIT: state_q <= ALIVE;
          ALIVE: begin
            if (rise) begin
              hit_q <= 1'b1;
              if (hit_health == '0) begin
                state_q <= DEAD;
                health_q <= '0;
                game_end_q <= 1'b1;
              end else begin
                state_q <= INVULN;
                health_q <= hit_heal;
                invuln_q <= 1'b1;
              end
            end else health_q <= cur_heal;
          end
          INVULN: begin
            health_q <= cur_heal;
            if (done) begin
              state_q <= ALIVE;
              invuln_q <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end
  assign healthCount = health_q;
  assign gameEnd = game_end_q;
  assign invulnerable = invuln_q;
  assign hitPulse = hit_q;
endmodule

// File: tb/tb_health_tracker.sv
// tb_health_tracker: randomized and directed checks of two health_tracker configurations against a behavioural model
module tb_health_tracker;
`ifdef HEALTH_TRACKER_HEAL_EN
  localparam bit HEAL_EN = 1'b1;
`else
  localparam bit HEAL_EN = 1'b0;
`endif
  logic Clk = 1'b0, Reset_n = 1'b0, restart = 1'b0, collision = 1'b1, heal = 1'b0;
  logic [1:0] dmg0 = 2'd1, hc0;
  logic [2:0] dmg1 = 3'd1, hc1;
  logic ge0, iv0, hp0, ge1, iv1, hp1;
  int vectors = 0, fails = 0;
  int maxh[2] = '{3, 5};
  int invn[2] = '{60, 4};
  int m_mode[2], m_h[2], m_left[2], m_prev[2], m_hp[2], m_exp[2];

  always #5 Clk = ~Clk;

  health_tracker u0 (.Clk(Clk), .Reset_n(Reset_n), .restart(restart), .collision(collision), .dmg(dmg0), .heal(heal),
    .healthCount(hc0), .gameEnd(ge0), .invulnerable(iv0), .hitPulse(hp0));
  health_tracker #(.MAX_HEALTH(5), .INVULN_CYCLES(4)) u1 (.Clk(Clk), .Reset_n(Reset_n), .restart(restart),
    .collision(collision), .dmg(dmg1), .heal(heal), .healthCount(hc1), .gameEnd(ge1), .invulnerable(iv1), .hitPulse(hp1));

  // mode: 0 init, 1 alive, 2 invulnerable, 3 dead; m_left = invulnerable cycles still to show
  function automatic void step(int i, bit rn, bit rs, bit col, int d, bit hl);
    bit rise;
    m_hp[i] = 0;
    if (!rn) begin
      m_mode[i] = 0; m_h[i] = maxh[i]; m_left[i] = 0; m_prev[i] = 1;
    end else begin
      rise = col && (m_prev[i] == 0);
      m_prev[i] = col;
      if (rs) begin
        m_mode[i] = 0; m_h[i] = maxh[i]; m_left[i] = 0;
      end else if (m_mode[i] == 0) m_mode[i] = 1;
      else if (m_mode[i] == 1) begin
        if (rise) begin
          m_hp[i] = 1;
          m_h[i] = m_h[i] - ((d < 1) ? 1 : d);
          if (m_h[i] <= 0) begin m_h[i] = 0; m_mode[i] = 3; end
          else begin
            m_mode[i] = 2; m_left[i] = invn[i];
            if (HEAL_EN && hl && m_h[i] < maxh[i]) m_h[i]++;
          end
        end else if (HEAL_EN && hl && m_h[i] < maxh[i]) m_h[i]++;
      end else if (m_mode[i] == 2) begin
        if (HEAL_EN && hl && m_h[i] < maxh[i]) m_h[i]++;
        m_left[i]--;
        if (m_left[i] == 0) m_mode[i] = 1;
      end
    end
    m_exp[i] = m_h[i] * 8 + (m_mode[i] == 3 ? 4 : 0) + (m_mode[i] == 2 ? 2 : 0) + m_hp[i];
  endfunction

  task automatic tick();
    @(posedge Clk);
    step(0, Reset_n, restart, collision, int'(dmg0), heal);
    step(1, Reset_n, restart, collision, int'(dmg1), heal);
    #1;
  endtask

  task automatic test_reset();
    Reset_n = 0; collision = 1;
    repeat (3) begin
      tick(); vectors += 2;
      if ({hc0, ge0, iv0, hp0} !== 5'(m_exp[0])) begin fails++; $display("FAIL reset dut0 t=%0t got %b exp %b", $time, {hc0, ge0, iv0, hp0}, 5'(m_exp[0])); end
      if ({hc1, ge1, iv1, hp1} !== 6'(m_exp[1])) begin fails++; $display("FAIL reset dut1 t=%0t got %b exp %b", $time, {hc1, ge1, iv1, hp1}, 6'(m_exp[1])); end
    end
    Reset_n = 1;
    repeat (10) begin
      tick(); vectors += 2;
      if ({hc0, ge0, iv0, hp0} !== 5'(m_exp[0])) begin fails++; $display("FAIL held_coll dut0 t=%0t got %b exp %b", $time, {hc0, ge0, iv0, hp0}, 5'(m_exp[0])); end
      if (hc0 !== 2'd3 || hp0 !== 1'b0) begin fails++; $display("FAIL held_coll_const t=%0t got hc=%0d hp=%b exp hc=3 hp=0", $time, hc0, hp0); end
    end
    collision = 0;
    repeat (3) tick();
  endtask

  task automatic test_hits();
    int cnt;
    dmg0 = 1; dmg1 = 1;
    for (int k = 0; k < 3; k++) begin
      collision = 1; cnt = 0;
      tick(); vectors += 2;
      if ({hc0, ge0, iv0, hp0} !== 5'(m_exp[0])) begin fails++; $display("FAIL hit%0d dut0 got %b exp %b", k, {hc0, ge0, iv0, hp0}, 5'(m_exp[0])); end
      if (hc0 !== 2'(2 - k)) begin fails++; $display("FAIL hit%0d_health got %0d exp %0d", k, hc0, 2 - k); end
      if (k == 2) begin
        vectors++;
        if (ge0 !== 1'b1) begin fails++; $display("FAIL dead_after_third got gameEnd=%b exp 1", ge0); end
      end
      cnt += int'(iv0);
      collision = 0;
      repeat (69) begin
        tick(); vectors += 2; cnt += int'(iv0);
        if ({hc0, ge0, iv0, hp0} !== 5'(m_exp[0])) begin fails++; $display("FAIL hits dut0 t=%0t got %b exp %b", $time, {hc0, ge0, iv0, hp0}, 5'(m_exp[0])); end
        if ({hc1, ge1, iv1, hp1} !== 6'(m_exp[1])) begin fails++; $display("FAIL hits dut1 t=%0t got %b exp %b", $time, {hc1, ge1, iv1, hp1}, 6'(m_exp[1])); end
      end
      if (k < 2) begin
        vectors++;
        if (cnt != 60) begin fails++; $display("FAIL invuln_len hit%0d got %0d cycles exp 60", k, cnt); end
      end
    end
  endtask

  task automatic test_restart();
    restart = 1;
    tick(); vectors += 3;
    restart = 0;
    if ({hc0, ge0, iv0, hp0} !== 5'(m_exp[0])) begin fails++; $display("FAIL restart dut0 got %b exp %b", {hc0, ge0, iv0, hp0}, 5'(m_exp[0])); end
    if ({hc1, ge1, iv1, hp1} !== 6'(m_exp[1])) begin fails++; $display("FAIL restart dut1 got %b exp %b", {hc1, ge1, iv1, hp1}, 6'(m_exp[1])); end
    if (hc0 !== 2'd3 || ge0 !== 1'b0) begin fails++; $display("FAIL restart_const got hc=%0d ge=%b exp hc=3 ge=0", hc0, ge0); end
    repeat (3) begin
      tick(); vectors += 2;
      if ({hc0, ge0, iv0, hp0} !== 5'(m_exp[0])) begin fails++; $display("FAIL post_restart dut0 got %b exp %b", {hc0, ge0, iv0, hp0}, 5'(m_exp[0])); end
      if ({hc1, ge1, iv1, hp1} !== 6'(m_exp[1])) begin fails++; $display("FAIL post_restart dut1 got %b exp %b", {hc1, ge1, iv1, hp1}, 6'(m_exp[1])); end
    end
  endtask

  task automatic test_invuln_ignore();
    dmg0 = 1; dmg1 = 1;
    repeat (7) tick();
    for (int c = 0; c < 100; c++) begin
      collision = (c == 0 || c >= 20) ? 1'b1 : 1'b0;
      tick(); vectors += 2;
      if ({hc0, ge0, iv0, hp0} !== 5'(m_exp[0])) begin fails++; $display("FAIL invuln_ignore dut0 c=%0d got %b exp %b", c, {hc0, ge0, iv0, hp0}, 5'(m_exp[0])); end
      if ({hc1, ge1, iv1, hp1} !== 6'(m_exp[1])) begin fails++; $display("FAIL invuln_ignore dut1 c=%0d got %b exp %b", c, {hc1, ge1, iv1, hp1}, 6'(m_exp[1])); end
    end
    vectors++;
    if (hc0 !== 2'd2 || iv0 !== 1'b0) begin fails++; $display("FAIL held_through_expiry got hc=%0d inv=%b exp hc=2 inv=0", hc0, iv0); end
    collision = 0;
    tick();
  endtask

  task automatic test_dmg();
    restart = 1; tick(); restart = 0; repeat (2) tick();
    dmg0 = 0; dmg1 = 0; collision = 1;
    tick(); vectors += 2;
    if (hc1 !== 3'd4 || hp1 !== 1'b1) begin fails++; $display("FAIL dmg_zero dut1 got hc=%0d hp=%b exp hc=4 hp=1", hc1, hp1); end
    if (hc0 !== 2'd2) begin fails++; $display("FAIL dmg_zero dut0 got hc=%0d exp 2", hc0); end
    collision = 0; repeat (6) tick();
    dmg1 = 7; collision = 1;
    tick(); vectors += 2;
    if (hc1 !== 3'd0 || ge1 !== 1'b1) begin fails++; $display("FAIL dmg_big dut1 got hc=%0d ge=%b exp hc=0 ge=1", hc1, ge1); end
    if ({hc1, ge1, iv1, hp1} !== 6'(m_exp[1])) begin fails++; $display("FAIL dmg_big_model dut1 got %b exp %b", {hc1, ge1, iv1, hp1}, 6'(m_exp[1])); end
    collision = 0;
    repeat (5) begin
      tick(); vectors++;
      if (ge1 !== 1'b1 || hc1 !== 3'd0) begin fails++; $display("FAIL dead_sticky got hc=%0d ge=%b exp hc=0 ge=1", hc1, ge1); end
    end
  endtask

  task automatic test_heal();
    restart = 1; tick(); restart = 0; repeat (2) tick();
    dmg0 = 1; collision = 1; tick(); collision = 0; repeat (65) tick();
    collision = 1; heal = 1; tick(); collision = 0; heal = 0; vectors++;
    if (hc0 !== (HEAL_EN ? 2'd2 : 2'd1)) begin fails++; $display("FAIL hit_and_heal got hc=%0d exp %0d", hc0, HEAL_EN ? 2 : 1); end
    repeat (65) tick();
    heal = 1; tick(); heal = 0; tick(); heal = 1; tick(); heal = 0; vectors += 2;
    if (hc0 !== (HEAL_EN ? 2'd3 : 2'd1)) begin fails++; $display("FAIL heal_sat got hc=%0d exp %0d", hc0, HEAL_EN ? 3 : 1); end
    if ({hc0, ge0, iv0, hp0} !== 5'(m_exp[0])) begin fails++; $display("FAIL heal_model dut0 got %b exp %b", {hc0, ge0, iv0, hp0}, 5'(m_exp[0])); end
    if (HEAL_EN) begin
      dmg0 = 2; collision = 1; tick(); collision = 0; repeat (65) tick();
      dmg0 = 1; collision = 1; heal = 1; tick(); collision = 0; heal = 0; vectors++;
      if (hc0 !== 2'd0 || ge0 !== 1'b1) begin fails++; $display("FAIL hit_heal_dead got hc=%0d ge=%b exp hc=0 ge=1", hc0, ge0); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 4000; c++) begin
      Reset_n = ($urandom_range(0, 399) != 0);
      restart = ($urandom_range(0, 249) == 0);
      collision = ($urandom_range(0, 5) == 0) ? ~collision : collision;
      dmg0 = 2'($urandom_range(0, 3));
      dmg1 = 3'($urandom_range(0, 7));
      heal = ($urandom_range(0, 15) == 0);
      tick(); vectors += 2;
      if ({hc0, ge0, iv0, hp0} !== 5'(m_exp[0])) begin fails++; $display("FAIL random dut0 c=%0d got %b exp %b", c, {hc0, ge0, iv0, hp0}, 5'(m_exp[0])); end
      if ({hc1, ge1, iv1, hp1} !== 6'(m_exp[1])) begin fails++; $display("FAIL random dut1 c=%0d got %b exp %b", c, {hc1, ge1, iv1, hp1}, 6'(m_exp[1])); end
    end
  endtask

  initial begin
    test_reset();
    test_hits();
    test_restart();
    test_invuln_ignore();
    test_dmg();
    test_restart();
    test_heal();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule

// File: doc/health_tracker.md
HEALTH_TRACKER -- requirements
Module: health_tracker

Interface
REQ-001 SHALL have parameter MAX_HEALTH, default 3, meaning starting and maximum health (integer 1..15).
REQ-002 SHALL have parameter INVULN_CYCLES, default 60, meaning length of the post-hit invulnerability window in Clk cycles (1..65535).
REQ-003 SHALL derive localparam HW = $clog2(MAX_HEALTH+1) and IW = $clog2(INVULN_CYCLES+1).
REQ-004 Clk  input  1  the single clock; all state changes occur on its rising edge.
REQ-005 Reset_n  input  1  synchronous active-low reset.
REQ-006 restart  input  1  level; when sampled high, returns the block to full health.
REQ-007 collision  input  1  level; a hit is counted only on its 0->1 transition.
REQ-008 dmg  input  HW  damage amount applied on a counted hit; 0 is treated as 1.
REQ-009 heal  input  1  single-cycle pulse; adds 1 health.
REQ-010 healthCount  output  HW  current health.
REQ-011 gameEnd  output  1  high while in DEAD.
REQ-012 invulnerable  output  1  high while in INVULN.
REQ-013 hitPulse  output  1  one-cycle pulse on the cycle after a counted hit.

Function
REQ-014 SHALL implement states INIT, ALIVE, INVULN and DEAD.
REQ-015 INIT -> ALIVE unconditionally on the next cycle; healthCount = MAX_HEALTH in INIT.
REQ-016 SHALL register collision each cycle; rising edge = collision & ~collision_q.
REQ-017 In ALIVE, a rising edge SHALL subtract max(dmg,1), saturating at 0.
REQ-018 After a hit: result 0 -> DEAD; otherwise -> INVULN with the invulnerability counter loaded to INVULN_CYCLES-1.
REQ-019 In INVULN, collision edges SHALL be ignored; the counter decrements each cycle; INVULN -> ALIVE on the cycle after the counter reaches 0, giving exactly INVULN_CYCLES cycles of invulnerable high.
REQ-020 A collision held high across INVULN expiry SHALL NOT count as a hit; a new 0->1 edge is required.
REQ-021 DEAD SHALL be sticky: healthCount = 0 and gameEnd = 1 until restart or reset.
REQ-022 restart high in any state SHALL go to INIT on the next cycle, clear the counter, and have priority over collision and heal.
REQ-023 A hit and a heal in the same ALIVE cycle SHALL apply damage first; if the result is 0, go to DEAD and drop the heal; otherwise add the heal.
REQ-024 healthCount and all outputs SHALL be registered, with one-cycle latency from the sampled input.

Reset
REQ-025 On Reset_n = 0 at a rising Clk edge: state = INIT, healthCount = MAX_HEALTH, gameEnd = 0, invulnerable = 0, hitPulse = 0, counter = 0, collision_q = 1.
REQ-026 Because collision_q resets to 1, a collision held high through reset SHALL NOT count as a hit.
REQ-027 Reset asserted mid-INVULN or in DEAD SHALL abort immediately, with no residual pulse.

Configuration
REQ-028 Macro HEALTH_TRACKER_HEAL_EN.
- Defined: heal increments healthCount by 1, saturating at MAX_HEALTH; accepted in ALIVE and INVULN only, ignored in INIT and DEAD.
- Undefined: the heal port still exists but is ignored; no heal logic is synthesised.

Structure
REQ-029 Shared package health_pkg SHALL hold the state enum health_state_t (INIT, ALIVE, INVULN, DEAD) and constants DEFAULT_MAX_HEALTH = 3 and DEFAULT_INVULN_CYCLES = 60.
REQ-030 The invulnerability timer SHALL be a sub-module invuln_timer (load, count-down, done flag, width IW).

Verification
REQ-031 Reset release, then collision held high from reset -> healthCount stays 3, hitPulse never asserts.
REQ-032 Defaults, three rising edges each spaced at least 61 cycles apart -> healthCount 2, 1, 0; gameEnd = 1 one cycle after the third edge; invulnerable high exactly 60 cycles after each of the first two hits.
REQ-033 Edge at cycle 10, second edge at cycle 30 (inside INVULN) -> healthCount = 2 only; collision still high at expiry -> no decrement.
REQ-034 MAX_HEALTH = 5, dmg = 7 -> healthCount 0 and DEAD; dmg = 0 -> decrement by 1.
REQ-035 With HEALTH_TRACKER_HEAL_EN, health 1, same-cycle hit (dmg = 1) and heal -> DEAD, heal dropped; health 2, same-cycle hit and heal -> healthCount 2; heal at MAX -> stays MAX.
REQ-036 In DEAD, restart for one cycle -> INIT then ALIVE with healthCount = MAX_HEALTH and gameEnd = 0.
